// File: rtl/conv_pkg.sv
// Shared types and sizes for the convolution operand path.
//   DEPTH   : entries per operand array
//   LEN_W   : width of an operand length
//   WORD_W  : data word width (IEEE-754 double)
//   MAX_LEN : most words a packet can store, limited by array depth and length width
package conv_pkg;

    localparam int unsigned DEPTH   = 256;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned WORD_W  = 64;
    localparam int unsigned LEN_CAP = (1 << LEN_W) - 1;
    localparam int unsigned MAX_LEN = (DEPTH < LEN_CAP) ? DEPTH : LEN_CAP;

    typedef logic [WORD_W-1:0]   word_t;
    typedef word_t [DEPTH-1:0]   vec_t;
    typedef logic [LEN_W-1:0]    len_t;

    typedef enum logic [1:0] {
        LOAD_X1 = 2'd0,
        LOAD_X2 = 2'd1,
        HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/conv_operand_buf.sv
// One operand packet buffer: stores words at consecutive indices, latches the
// packet length on the last beat, flags words dropped beyond MAX_LEN.
//   clk, reset : clock, async active-high reset
//   wr_en      : accepted beat addressed to this buffer
//   wr_data    : beat data
//   clr        : synchronous clear of contents, length and flags
//   last       : beat is the final word of the packet
//   vec        : stored words, unwritten entries read 0
//   len        : latched packet length (0 until a packet completes)
//   overflow   : sticky, a word was dropped since the last clear
//   done_c     : combinational, final beat of the packet accepted this cycle
module conv_operand_buf
    import conv_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [WORD_W-1:0]             wr_data,
    input  logic                          clr,
    input  logic                          last,
    output logic [DEPTH-1:0][WORD_W-1:0]  vec,
    output logic [LEN_W-1:0]              len,
    output logic                          overflow,
    output logic                          done_c
);

    vec_t  r_vec;
    len_t  r_len;
    len_t  r_cnt;
    logic  r_ovf;

    logic  w_room;
    len_t  w_cnt_adv;
    len_t  w_cnt_nxt;
    len_t  w_len_nxt;
    logic  w_ovf_nxt;

    // Room left for another word; once full, the count stops advancing
    assign w_room    = (r_cnt < LEN_W'(MAX_LEN));
    assign w_cnt_adv = w_room ? (r_cnt + LEN_W'(1)) : r_cnt;

    // Next count/length/overflow for a beat
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_len_nxt = r_len;
        w_ovf_nxt = r_ovf;
        if (clr) begin
            w_cnt_nxt = '0;
            w_len_nxt = '0;
            w_ovf_nxt = 1'b0;
        end else if (wr_en) begin
            if (!w_room) begin
                w_ovf_nxt = 1'b1;
            end
            if (last) begin
                w_len_nxt = w_cnt_adv;
                w_cnt_nxt = '0;
            end else begin
                w_cnt_nxt = w_cnt_adv;
            end
        end
    end

    // Control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_len <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_len <= w_len_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    // Word storage; a word past MAX_LEN is dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vec <= '0;
        end else if (clr) begin
            r_vec <= '0;
        end else if (wr_en && w_room) begin
            r_vec[r_cnt] <= wr_data;
        end
    end

    assign vec      = r_vec;
    assign len      = r_len;
    assign overflow = r_ovf;
    assign done_c   = wr_en && last && !clr;

endmodule

// File: rtl/conv_operand_loader.sv
// Upstream feeder for the convolution stage. Takes a matrix packet then a
// kernel packet of 64-bit words from a valid/ready stream and holds them as a
// stable operand set until the consumer acknowledges.
//   clk, reset : clock, async active-high reset
//   s_valid    : stream word valid
//   s_ready    : loader can accept a word (low while holding operands)
//   s_data     : stream word, passed through bit-exact
//   s_last     : final word of the current packet
//   x1, len1   : matrix operand and its length
//   x2, len2   : kernel operand and its length
//   op_valid   : operand set complete and stable
//   op_ack     : consumer has taken the operands
//   err        : {kernel_longer_than_matrix, overflow}, zero unless op_valid
module conv_operand_loader
    import conv_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [WORD_W-1:0]             s_data,
    input  logic                          s_last,
    output logic [DEPTH-1:0][WORD_W-1:0]  x1,
    output logic [LEN_W-1:0]              len1,
    output logic [DEPTH-1:0][WORD_W-1:0]  x2,
    output logic [LEN_W-1:0]              len2,
    output logic                          op_valid,
    input  logic                          op_ack,
    output logic [1:0]                    err
);

    state_t r_state;
    state_t w_state_nxt;
    logic   r_s_ready;
    logic   r_op_valid;

    logic   w_beat;
    logic   w_wr1;
    logic   w_wr2;
    logic   w_clr;
    logic   w_done1_c;
    logic   w_done2_c;
    logic   w_ovf1;
    logic   w_ovf2;
    logic [1:0] w_err;

    assign w_beat = s_valid && r_s_ready;
    assign w_wr1  = w_beat && (r_state == LOAD_X1);
    assign w_wr2  = w_beat && (r_state == LOAD_X2);
    // Ack only counts while operands are presented
    assign w_clr  = op_ack && r_op_valid;

    conv_operand_buf u_buf_x1 (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (w_wr1),
        .wr_data  (s_data),
        .clr      (w_clr),
        .last     (s_last),
        .vec      (x1),
        .len      (len1),
        .overflow (w_ovf1),
        .done_c   (w_done1_c)
    );

    conv_operand_buf u_buf_x2 (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (w_wr2),
        .wr_data  (s_data),
        .clr      (w_clr),
        .last     (s_last),
        .vec      (x2),
        .len      (len2),
        .overflow (w_ovf2),
        .done_c   (w_done2_c)
    );

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LOAD_X1: if (w_done1_c) w_state_nxt = LOAD_X2;
            LOAD_X2: if (w_done2_c) w_state_nxt = HOLD;
            HOLD:    if (w_clr)     w_state_nxt = LOAD_X1;
            default:                w_state_nxt = LOAD_X1;
        endcase
    end

    // State register; s_ready and op_valid are decoded from the next state
    // so both line up with the state they describe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= LOAD_X1;
            r_s_ready  <= 1'b1;
            r_op_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_s_ready  <= (w_state_nxt != HOLD);
            r_op_valid <= (w_state_nxt == HOLD);
        end
    end

    // Error flags derive from registered lengths/flags, which are final in
    // the first HOLD cycle, and are masked outside HOLD
    always_comb begin
        w_err = 2'b00;
        if (r_op_valid) begin
            w_err = {(len2 > len1), (w_ovf1 || w_ovf2)};
        end
    end

    assign s_ready  = r_s_ready;
    assign op_valid = r_op_valid;
    assign err      = w_err;

endmodule

// File: tb/tb_conv_operand_loader.sv
module tb_conv_operand_loader;
    import conv_pkg::*;

    localparam int MODEL_MAX = 255;

    logic clk;
    logic reset;
    logic s_valid;
    logic s_ready;
    logic [63:0] s_data;
    logic s_last;
    logic [DEPTH-1:0][63:0] x1;
    logic [DEPTH-1:0][63:0] x2;
    logic [7:0] len1;
    logic [7:0] len2;
    logic op_valid;
    logic op_ack;
    logic [1:0] err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] mat_q[$];
    logic [63:0] ker_q[$];

    typedef struct {
        int         n_mat;
        int         n_ker;
        int         bubble;
        int         exp_len1;
        int         exp_len2;
        logic [1:0] exp_err;
    } vec_rec_t;

    vec_rec_t tbl[6];

    conv_operand_loader dut (
        .clk      (clk),
        .reset    (reset),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .x1       (x1),
        .len1     (len1),
        .x2       (x2),
        .len2     (len2),
        .op_valid (op_valid),
        .op_ack   (op_ack),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a word is stored if it is among the first MODEL_MAX of its packet
    function automatic logic [63:0] exp_word(input bit kern, input int i);
        if (kern) return (i < ker_q.size() && i < MODEL_MAX) ? ker_q[i] : 64'd0;
        return (i < mat_q.size() && i < MODEL_MAX) ? mat_q[i] : 64'd0;
    endfunction

    function automatic int exp_len(input int n);
        return (n < MODEL_MAX) ? n : MODEL_MAX;
    endfunction

    function automatic logic [1:0] exp_err();
        logic longer;
        logic ovf;
        longer = exp_len(ker_q.size()) > exp_len(mat_q.size());
        ovf    = (mat_q.size() > MODEL_MAX) || (ker_q.size() > MODEL_MAX);
        return {longer, ovf};
    endfunction

    task automatic chk_arrays(input string tag);
        int  b1 = 0;
        int  b2 = 0;
        bit  f1 = 0;
        bit  f2 = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!f1 && x1[i] !== exp_word(0, i)) begin f1 = 1; b1 = i; end
            if (!f2 && x2[i] !== exp_word(1, i)) begin f2 = 1; b2 = i; end
        end
        chk({tag, "_x1"}, x1[b1], exp_word(0, b1));
        chk({tag, "_x2"}, x2[b2], exp_word(1, b2));
    endtask

    task automatic chk_hold(input string tag);
        chk({tag, "_op_valid"}, 64'(op_valid), 64'd1);
        chk({tag, "_s_ready"},  64'(s_ready),  64'd0);
        chk({tag, "_len1"},     64'(len1),     64'(exp_len(mat_q.size())));
        chk({tag, "_len2"},     64'(len2),     64'(exp_len(ker_q.size())));
        chk({tag, "_err"},      64'(err),      64'(exp_err()));
        chk_arrays(tag);
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_op_valid"}, 64'(op_valid), 64'd0);
        chk({tag, "_s_ready"},  64'(s_ready),  64'd1);
        chk({tag, "_len1"},     64'(len1),     64'd0);
        chk({tag, "_len2"},     64'(len2),     64'd0);
        chk({tag, "_err"},      64'(err),      64'd0);
        chk_arrays(tag);
    endtask

    // Inputs change at negedge; the beat happens at the following posedge
    task automatic send_pkt(input bit kern, input int bubble, input bit rand_ack);
        int n;
        n = kern ? ker_q.size() : mat_q.size();
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 20 && $urandom_range(99) < bubble; b++) begin
                s_valid = 1'b0;
                s_data  = {$urandom, $urandom};
                s_last  = 1'($urandom_range(1));
                op_ack  = rand_ack && ($urandom_range(1) == 1);
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_data  = kern ? ker_q[i] : mat_q[i];
            s_last  = (i == n - 1);
            op_ack  = rand_ack && ($urandom_range(1) == 1);
            if (kern && i == n - 1) chk("op_valid_before_last", 64'(op_valid), 64'd0);
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        op_ack  = 1'b0;
    endtask

    task automatic load(input int bubble, input bit rand_ack);
        send_pkt(0, bubble, rand_ack);
        send_pkt(1, bubble, rand_ack);
        chk("op_valid_after_last", 64'(op_valid), 64'd1);
    endtask

    task automatic ack_and_check(input string tag);
        op_ack = 1'b1;
        @(negedge clk);
        op_ack = 1'b0;
        mat_q.delete();
        ker_q.delete();
        chk_empty(tag);
    endtask

    task automatic fill_frac(input int nm, input int nk);
        mat_q.delete();
        ker_q.delete();
        for (int i = 0; i < nm; i++) mat_q.push_back($realtobits(real'(i + 1) / 10.0));
        for (int i = 0; i < nk; i++) ker_q.push_back($realtobits(real'(i + 1) / 10.0));
    endtask

    task automatic fill_rand(input int nm, input int nk);
        mat_q.delete();
        ker_q.delete();
        for (int i = 0; i < nm; i++) mat_q.push_back({$urandom, $urandom});
        for (int i = 0; i < nk; i++) ker_q.push_back({$urandom, $urandom});
    endtask

    initial begin
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        op_ack  = 1'b0;
        reset   = 1'b0;
        #1 reset = 1'b1;
        #11 reset = 1'b0;
        @(negedge clk);
        chk_empty("reset");

        // Nominal load with explicit spot values
        fill_frac(16, 4);
        load(0, 0);
        chk_hold("nominal");
        chk("nom_x1_0",  x1[0],  $realtobits(0.1));
        chk("nom_x1_15", x1[15], $realtobits(1.6));
        chk("nom_x1_16", x1[16], 64'd0);
        chk("nom_x2_3",  x2[3],  $realtobits(0.4));

        // Hold: stream activity must not disturb the operands
        for (int c = 0; c < 5; c++) begin
            s_valid = 1'b1;
            s_data  = {$urandom, $urandom};
            s_last  = 1'($urandom_range(1));
            @(negedge clk);
            chk_hold("hold");
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        ack_and_check("ack");

        // Overflow spot values
        fill_rand(300, 4);
        load(0, 0);
        chk_hold("ovf");
        chk("ovf_x1_254", x1[254], mat_q[254]);
        chk("ovf_x1_255", x1[255], 64'd0);
        ack_and_check("ovf_ack");

        // Table-driven cases
        tbl[0] = '{n_mat: 16,  n_ker: 4,   bubble: 0,  exp_len1: 16,  exp_len2: 4,   exp_err: 2'b00};
        tbl[1] = '{n_mat: 3,   n_ker: 5,   bubble: 0,  exp_len1: 3,   exp_len2: 5,   exp_err: 2'b10};
        tbl[2] = '{n_mat: 1,   n_ker: 1,   bubble: 50, exp_len1: 1,   exp_len2: 1,   exp_err: 2'b00};
        tbl[3] = '{n_mat: 255, n_ker: 255, bubble: 0,  exp_len1: 255, exp_len2: 255, exp_err: 2'b00};
        tbl[4] = '{n_mat: 256, n_ker: 300, bubble: 10, exp_len1: 255, exp_len2: 255, exp_err: 2'b01};
        tbl[5] = '{n_mat: 2,   n_ker: 260, bubble: 0,  exp_len1: 2,   exp_len2: 255, exp_err: 2'b11};
        for (int t = 0; t < 6; t++) begin
            fill_frac(tbl[t].n_mat, tbl[t].n_ker);
            if (t == 2) begin
                mat_q[0] = $realtobits(1.0);
                ker_q[0] = $realtobits(2.0);
            end
            load(tbl[t].bubble, 0);
            chk($sformatf("tbl%0d_len1", t), 64'(len1), 64'(tbl[t].exp_len1));
            chk($sformatf("tbl%0d_len2", t), 64'(len2), 64'(tbl[t].exp_len2));
            chk($sformatf("tbl%0d_err", t),  64'(err),  64'(tbl[t].exp_err));
            chk_hold($sformatf("tbl%0d", t));
            if (t == 2) begin
                chk("single_x1_0", x1[0], $realtobits(1.0));
                chk("single_x2_0", x2[0], $realtobits(2.0));
            end
            ack_and_check($sformatf("tbl%0d_ack", t));
        end

        // Async reset in the middle of a matrix packet
        fill_frac(7, 0);
        for (int i = 0; i < 7; i++) begin
            s_valid = 1'b1;
            s_data  = mat_q[i];
            s_last  = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        mat_q.delete();
        chk_empty("async_rst");
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk_empty("post_rst");
        fill_frac(16, 4);
        load(0, 0);
        chk_hold("post_rst_nominal");
        ack_and_check("post_rst_ack");

        // Random sizes, data, bubbles and stray acks while loading
        for (int r = 0; r < 8; r++) begin
            int nm;
            int nk;
            nm = ($urandom_range(3) == 0) ? int'($urandom_range(250, 262)) : int'($urandom_range(1, 40));
            nk = int'($urandom_range(1, 40));
            fill_rand(nm, nk);
            load(30, 1);
            chk_hold($sformatf("rand%0d", r));
            ack_and_check($sformatf("rand%0d_ack", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
